// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - frame-based serial transmitter (start, LSB-first data, optional even parity, stop)
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TICK_W-1:0]   tick;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_shift;
    logic                parity_bit;
    logic                bit_end;
    logic                last_bit;

    // A bit ends on the edge where the tick counter reaches its terminal count.
    assign bit_end     = (state != IDLE) && (tick == TICK_LAST);
    assign last_bit    = (bit_cnt == BIT_LAST);
    assign shreg_shift = shreg >> 1;

    // State register; en=0 freezes the FSM, reset abandons any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state selection; the parity state is bypassed when parity is disabled.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_valid) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        tx_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Datapath: bit timing, shift register, registered line level and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            done       <= 1'b0;
        end else if (en) begin
            done <= (state == STOP) && bit_end;
            if (state == IDLE || bit_end) begin
                tick <= '0;
            end else begin
                tick <= tick + TICK_W'(1);
            end
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        parity_bit <= ^tx_data;
                        tx_out     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) tx_out <= shreg[0];
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg_shift;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            tx_out  <= (PARITY_EN != 0) ? parity_bit : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tx_out  <= shreg_shift[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) tx_out <= 1'b1;
                end
                STOP: begin
                    tx_out <= 1'b1;
                end
                default: begin
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed bench for serial_tx with and without parity
module tb_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic tx_ready_0, tx_out_0, busy_0, done_0;
    logic tx_ready_p, tx_out_p, busy_p, done_p;

    int checks = 0;
    int errors = 0;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut (
        .clk      (clk),
        .rst      (rst_n),
        .en       (en),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready_0),
        .tx_out   (tx_out_0),
        .busy     (busy_0),
        .done     (done_0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_p (
        .clk      (clk),
        .rst      (rst_n),
        .en       (en),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready_p),
        .tx_out   (tx_out_p),
        .busy     (busy_p),
        .done     (done_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends word d and checks every cycle of the frame against bits (index 0 = start bit).
    // Starts and ends on a falling edge; ends on the cycle right after the return to idle.
    task automatic run_frame(input logic par, input logic [7:0] d, input logic [15:0] bits,
                             input int nbits, input logic hold, input logic [7:0] next_d,
                             input int stall_at, input int stall_len);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        if (hold) tx_data = next_d;
        else      tx_valid = 1'b0;
        for (int j = 0; j < nbits * 4; j++) begin
            if (j > 0) @(negedge clk);
            chk("frame tx_out", par ? tx_out_p : tx_out_0, bits[j / 4]);
            chk("frame busy",   par ? busy_p : busy_0, 1);
            chk("frame done",   par ? done_p : done_0, 0);
            if (j == stall_at) begin
                en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall tx_out", par ? tx_out_p : tx_out_0, bits[j / 4]);
                    chk("stall busy",   par ? busy_p : busy_0, 1);
                end
                en = 1'b1;
            end
        end
        @(negedge clk);
        chk("end done",     par ? done_p : done_0, 1);
        chk("end busy",     par ? busy_p : busy_0, 0);
        chk("end tx_ready", par ? tx_ready_p : tx_ready_0, 1);
        chk("end tx_out",   par ? tx_out_p : tx_out_0, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tx_valid = 1'($urandom_range(0, 1));
            en       = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            chk("rst tx_out",   tx_out_0, 1);
            chk("rst tx_ready", tx_ready_0, 1);
            chk("rst busy",     busy_0, 0);
            chk("rst done",     done_0, 0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        en       = 1'b1;
        rst_n    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle tx_out",   tx_out_0, 1);
            chk("idle tx_ready", tx_ready_0, 1);
            chk("idle busy",     busy_0, 0);
            chk("idle done",     done_0, 0);
        end

        // Basic frame 8'hA5, no parity: 0,1,0,1,0,0,1,0,1,1
        run_frame(1'b0, 8'hA5, 16'b11_0100_1010, 10, 1'b0, 8'h00, -1, 0);
        @(negedge clk);
        chk("done single pulse", done_0, 0);
        chk("post frame tx_out", tx_out_0, 1);
        repeat (8) @(negedge clk);

        // Parity 8'hA5 -> parity 0, 44 cycles
        run_frame(1'b1, 8'hA5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 8'h00, -1, 0);
        @(negedge clk);
        chk("parity done pulse", done_p, 0);
        repeat (8) @(negedge clk);

        // Accept deferred while en=0
        en       = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h07;
        @(negedge clk);
        chk("en0 no accept ready",  tx_ready_p, 1);
        chk("en0 no accept tx_out", tx_out_p, 1);
        en = 1'b1;

        // Parity 8'h07 -> parity 1
        run_frame(1'b1, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 8'h00, -1, 0);
        repeat (10) @(negedge clk);

        // Back-to-back: 8'h00 then 8'hFF with tx_valid held, data changed mid-frame
        run_frame(1'b0, 8'h00, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 1'b1, 8'hFF, -1, 0);
        run_frame(1'b0, 8'hFF, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 8'h00, -1, 0);
        repeat (10) @(negedge clk);

        // Enable stall of 7 cycles inside data bit 3
        run_frame(1'b0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'h00, 17, 7);
        repeat (10) @(negedge clk);

        // Mid-frame asynchronous reset during data bit 5 of 8'h5A (bit 5 = 0)
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (24) @(negedge clk);
        chk("pre-reset bit5", tx_out_0, 0);
        chk("pre-reset busy", busy_0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst tx_out",   tx_out_0, 1);
        chk("async rst tx_ready", tx_ready_0, 1);
        chk("async rst busy",     busy_0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 8'h3C, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 8'h00, -1, 0);
        @(negedge clk);
        chk("final done clear", done_0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Frame-based serial transmitter. Accepts a parallel word over a valid/ready handshake and drives it onto a one-bit line:
- Frame format: start bit (0), DATA_W data bits LSB-first, optional even-parity bit, stop bit (1).
- Each bit is held for CLKS_PER_BIT enabled clock cycles.
- The block is the driving end of the serial links whose receive side samples the line with the team's enabled D flip-flops. It sits between a parallel producer and the serial pin.

## Interface
- DATA_W, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 4, enabled clock cycles per serial bit (≥1)
- PARITY_EN, 0, 1 inserts an even-parity bit between the last data bit and the stop bit
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low; one clock domain only
- en  input  1  global enable; when 0, all state, counters and outputs hold
- tx_valid  input  1  producer has a word
- tx_data  input  DATA_W  word to send; sampled only at the accept edge
- tx_ready  output  1  block can accept a word; equals (state==IDLE)
- tx_out  output  1  serial line, registered; idle level 1
- busy  output  1  frame in progress; equals ~tx_ready
- done  output  1  one-cycle registered pulse after a frame's stop bit completes

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when PARITY_EN=0.
- Accept condition: rising edge with en=1, state=IDLE and tx_valid=1.
  - Latches tx_data into a shift register.
  - Next state is START; tx_out becomes 0.
- tick counter: counts 0..CLKS_PER_BIT-1 on enabled edges.
  - A bit ends on the enabled edge where tick = CLKS_PER_BIT-1. That edge clears tick and advances the bit or state.
- START: on bit end, go to DATA; tx_out = shreg[0].
- DATA: on each bit end, shift right and increment the bit counter.
  - After bit DATA_W-1 ends, go to PARITY (tx_out = XOR of the latched word), or to STOP when PARITY_EN=0 (tx_out = 1).
- PARITY: on bit end, go to STOP; tx_out = 1.
- STOP: on bit end, go to IDLE; tx_out stays 1; done = 1 for exactly the next cycle.
- Counter widths:
  - bit counter: $clog2(DATA_W) bits, minimum 1.
  - tick counter: $clog2(CLKS_PER_BIT) bits, minimum 1.
  - Both wrap only by explicit clear, never by overflow.
- Input rules:
  - tx_valid is ignored while busy. A word presented during a frame is not lost from the producer's view, because tx_ready stays 0.
  - tx_data changes after the accept edge do not affect the frame.
- en=0: state, tick, bit counter, shreg, tx_out and done all hold.
  - A done pulse pending when en falls stays high until the next enabled edge.
  - No accept occurs while en=0.
- Reset (rst=0), asynchronous and taking effect immediately, including mid-frame:
  - state=IDLE, tx_out=1, done=0, tick=0, bit counter=0, shreg=0.
  - As a result tx_ready=1 and busy=0.
  - A partially sent frame is abandoned. Nothing is retransmitted.
- After rst deasserts, the first rising edge can already accept a word.

## Timing
- Latency: accept at edge k → start bit visible on tx_out from just after edge k.
- Frame length: (DATA_W + 2 + PARITY_EN) × CLKS_PER_BIT enabled cycles, measured from edge k to the edge returning to IDLE.
- done and tx_ready rise together right after the final STOP edge.
- Back-to-back transfer when tx_valid is held high:
  - The next accept happens on the edge following the return to IDLE.
  - Minimum inter-frame idle time is exactly 1 cycle with tx_out=1.
- CLKS_PER_BIT=1: each bit lasts one cycle and tick stays 0.
- Simultaneous events:
  - Reset asserted on an accept edge wins; no frame starts.
  - en=0 on an accept edge wins; the accept is deferred.

## Test plan
- Reset values: hold rst=0 with random inputs → tx_out=1, tx_ready=1, busy=0, done=0. Release rst with tx_valid=0 → the outputs hold for 20 cycles.
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0, send 8'hA5.
  - tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
  - busy for 40 cycles; single done pulse at cycle 41.
- Parity: PARITY_EN=1.
  - Send 8'hA5 → parity bit 0; frame is 44 cycles.
  - Send 8'h07 → parity bit 1.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF → two frames separated by exactly 1 idle-high cycle. Data changes during the first frame do not corrupt it.
- Enable stall: drop en for 7 cycles in the middle of data bit 3 → tx_out and counters freeze. The frame resumes and is exactly 7 cycles longer, with an unchanged bit pattern.
- Mid-frame reset: assert rst=0 asynchronously (between edges) during data bit 5 → tx_out=1 and tx_ready=1 immediately. The next accepted word 8'h3C transmits a correct, complete frame.
